// File: rtl/qkd_pkg.sv
// Shared constants and types for the BB84 streaming frame loader.
package qkd_pkg;

    localparam int QKD_N     = 80;
    localparam int QKD_CNT_W = 7;

    localparam int SMP_ABIT  = 2;
    localparam int SMP_ABASE = 1;
    localparam int SMP_BBASE = 0;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } loader_state_e;

endpackage

// File: rtl/qkd_frame_buf.sv
// N-entry, 3-bit-wide shadow register file: one indexed write port and a
// full-width parallel read split into the three sample fields.
module qkd_frame_buf
    import qkd_pkg::*;
#(
    parameter int N     = QKD_N,
    parameter int CNT_W = QKD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_idx_i,
    input  logic [2:0]       wr_data_i,
    output logic [N-1:0]     abit_o,
    output logic [N-1:0]     abase_o,
    output logic [N-1:0]     bbase_o
);

    logic [N-1:0] abit_q;
    logic [N-1:0] abase_q;
    logic [N-1:0] bbase_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abit_q  <= '0;
            abase_q <= '0;
            bbase_q <= '0;
        end else if (wr_en_i) begin
            abit_q[wr_idx_i]  <= wr_data_i[SMP_ABIT];
            abase_q[wr_idx_i] <= wr_data_i[SMP_ABASE];
            bbase_q[wr_idx_i] <= wr_data_i[SMP_BBASE];
        end
    end

    assign abit_o  = abit_q;
    assign abase_o = abase_q;
    assign bbase_o = bbase_q;

endmodule

// File: rtl/qkd_frame_loader.sv
// Streaming sample-to-frame loader for the BB84 core, double-buffered via a
// shadow buffer. Optional match counter: define QKD_LOADER_MATCH_CNT_EN.
module qkd_frame_loader
    import qkd_pkg::*;
#(
    parameter int N     = QKD_N,
    parameter int CNT_W = QKD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [2:0]       s_data,
    output logic [N-1:0]     alice_bits,
    output logic [N-1:0]     alice_bases,
    output logic [N-1:0]     bob_bases,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic [CNT_W-1:0] fill_count
`ifdef QKD_LOADER_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N);

    loader_state_e    state_q;
    logic [CNT_W-1:0] fill_q;
    logic             fv_q;
    logic [N-1:0]     abit_q;
    logic [N-1:0]     abase_q;
    logic [N-1:0]     bbase_q;

    logic             accept;
    logic             last;
    logic             copy;
    logic [N-1:0]     buf_abit;
    logic [N-1:0]     buf_abase;
    logic [N-1:0]     buf_bbase;
    logic [N-1:0]     abit_d;
    logic [N-1:0]     abase_d;
    logic [N-1:0]     bbase_d;

    assign s_ready = (state_q == FILL);
    assign accept  = s_valid && s_ready;
    assign last    = accept && (fill_q == LAST_IDX);
    assign copy    = (last && (!fv_q || frame_ack)) || ((state_q == STALL) && frame_ack);

    qkd_frame_buf #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (accept),
        .wr_idx_i  (fill_q),
        .wr_data_i (s_data),
        .abit_o    (buf_abit),
        .abase_o   (buf_abase),
        .bbase_o   (buf_bbase)
    );

    // The N-th sample is still in flight on a FILL-state copy, so merge it in.
    always_comb begin
        abit_d  = buf_abit;
        abase_d = buf_abase;
        bbase_d = buf_bbase;
        if (accept) begin
            abit_d[fill_q]  = s_data[SMP_ABIT];
            abase_d[fill_q] = s_data[SMP_ABASE];
            bbase_d[fill_q] = s_data[SMP_BBASE];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            fill_q  <= '0;
            fv_q    <= 1'b0;
            abit_q  <= '0;
            abase_q <= '0;
            bbase_q <= '0;
        end else if (copy) begin
            state_q <= FILL;
            fill_q  <= '0;
            fv_q    <= 1'b1;
            abit_q  <= abit_d;
            abase_q <= abase_d;
            bbase_q <= bbase_d;
        end else begin
            if (last) begin
                state_q <= STALL;
                fill_q  <= FULL_CNT;
            end else if (accept) begin
                fill_q  <= fill_q + CNT_W'(1);
            end
            if (frame_ack && fv_q) begin
                fv_q <= 1'b0;
            end
        end
    end

    assign alice_bits  = abit_q;
    assign alice_bases = abase_q;
    assign bob_bases   = bbase_q;
    assign frame_valid = fv_q;
    assign fill_count  = fill_q;

`ifdef QKD_LOADER_MATCH_CNT_EN
    logic [CNT_W-1:0] shadow_match_q;
    logic [CNT_W-1:0] shadow_match_d;
    logic [CNT_W-1:0] match_q;

    // A sample accepted on a copy cycle is the last one of the copied frame,
    // so the shadow count always restarts from zero.
    assign shadow_match_d = shadow_match_q
                          + CNT_W'(accept && (s_data[SMP_ABASE] == s_data[SMP_BBASE]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_match_q <= '0;
            match_q        <= '0;
        end else if (copy) begin
            match_q        <= shadow_match_d;
            shadow_match_q <= '0;
        end else begin
            shadow_match_q <= shadow_match_d;
        end
    end

    assign match_count = match_q;
`endif

endmodule

// File: tb/tb_qkd_frame_loader.sv
// Directed self-checking bench for qkd_frame_loader; match_count checks are
// compiled in when QKD_LOADER_MATCH_CNT_EN is defined.
module tb_qkd_frame_loader;

    localparam int N     = 80;
    localparam int CNT_W = 7;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [2:0]       s_data;
    logic [N-1:0]     alice_bits;
    logic [N-1:0]     alice_bases;
    logic [N-1:0]     bob_bases;
    logic             frame_valid;
    logic             frame_ack;
    logic [CNT_W-1:0] fill_count;
`ifdef QKD_LOADER_MATCH_CNT_EN
    logic [CNT_W-1:0] match_count;
`endif

    int checkCount;
    int errorCount;

    logic [79:0] expBits;
    logic [79:0] expBases;
    logic [79:0] expBob;
    logic [79:0] prevBits;
    logic [79:0] prevBases;
    logic [79:0] prevBob;
    int          expMatch;
    int          prevMatch;
    int          gap;
    int          ackDelay;
    logic [2:0]  d;

    qkd_frame_loader #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .alice_bits  (alice_bits),
        .alice_bases (alice_bases),
        .bob_bases   (bob_bases),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .fill_count  (fill_count)
`ifdef QKD_LOADER_MATCH_CNT_EN
        ,
        .match_count (match_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [79:0] observed,
                               input logic [79:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Holds s_valid until the loader accepts; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] data);
        int waitCycles;
        waitCycles = 0;
        s_valid = 1'b1;
        s_data  = data;
        while (!s_ready && waitCycles < 500) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        if (!s_ready) checkOutput("readyTimeout", 80'(s_ready), 80'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic pulseAck();
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input logic [79:0] eb,
                              input logic [79:0] ea, input logic [79:0] eo, input int em);
        checkOutput({tag, "_bits"}, alice_bits, eb);
        checkOutput({tag, "_bases"}, alice_bases, ea);
        checkOutput({tag, "_bob"}, bob_bases, eo);
`ifdef QKD_LOADER_MATCH_CNT_EN
        checkOutput({tag, "_match"}, 80'(match_count), 80'(em));
`else
        if (em < 0) $display("[TB] unexpected negative match %0d", em);
`endif
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst        = 1'b0;
        s_valid    = 1'b0;
        s_data     = 3'b000;
        frame_ack  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_fill", 80'(fill_count), 80'(0));
        checkOutput("rst_valid", 80'(frame_valid), 80'(0));
        checkOutput("rst_ready", 80'(s_ready), 80'(1));
        checkFrame("rst", 80'h0, 80'h0, 80'h0, 0);
        rst = 1'b1;

        // Frame A: 3'b110 with no ack, copied straight out.
        for (int k = 0; k < 79; k++) applyStimulus(3'b110);
        checkOutput("a_fill79", 80'(fill_count), 80'(79));
        checkOutput("a_valid79", 80'(frame_valid), 80'(0));
        applyStimulus(3'b110);
        checkOutput("a_valid", 80'(frame_valid), 80'(1));
        checkOutput("a_ready", 80'(s_ready), 80'(1));
        checkOutput("a_fill", 80'(fill_count), 80'(0));
        checkFrame("a", {80{1'b1}}, {80{1'b1}}, 80'h0, 0);

        // Frame B: 3'b011 while A is held -> stall until ack.
        for (int k = 0; k < 80; k++) applyStimulus(3'b011);
        checkOutput("b_stallReady", 80'(s_ready), 80'(0));
        checkOutput("b_stallFill", 80'(fill_count), 80'(80));
        checkOutput("b_stallValid", 80'(frame_valid), 80'(1));
        checkFrame("b_held", {80{1'b1}}, {80{1'b1}}, 80'h0, 0);
        pulseAck();
        checkFrame("b", 80'h0, {80{1'b1}}, {80{1'b1}}, 80);
        checkOutput("b_ready", 80'(s_ready), 80'(1));
        checkOutput("b_fill", 80'(fill_count), 80'(0));
        checkOutput("b_valid", 80'(frame_valid), 80'(1));

        // Plain ack clears valid but leaves the vectors alone.
        pulseAck();
        checkOutput("ack_valid", 80'(frame_valid), 80'(0));
        checkFrame("ack_keep", 80'h0, {80{1'b1}}, {80{1'b1}}, 80);

        // Frame C: sample k = {k[0], k[1], k[0]}.
        for (int k = 0; k < 80; k++) begin
            d = {k[0], k[1], k[0]};
            applyStimulus(d);
        end
        checkOutput("c_valid", 80'(frame_valid), 80'(1));
        checkFrame("c", 80'hAAAA_AAAA_AAAA_AAAA_AAAA, 80'hCCCC_CCCC_CCCC_CCCC_CCCC,
                   80'hAAAA_AAAA_AAAA_AAAA_AAAA, 40);

        // Frame D: ack coincides with the 80th accept -> no stall.
        for (int k = 0; k < 79; k++) applyStimulus(3'b100);
        frame_ack = 1'b1;
        applyStimulus(3'b100);
        frame_ack = 1'b0;
        checkOutput("d_valid", 80'(frame_valid), 80'(1));
        checkOutput("d_ready", 80'(s_ready), 80'(1));
        checkOutput("d_fill", 80'(fill_count), 80'(0));
        checkFrame("d", {80{1'b1}}, 80'h0, 80'h0, 80);

        // Reset after 37 samples, then a clean frame.
        for (int k = 0; k < 37; k++) applyStimulus(3'b111);
        checkOutput("e_fill37", 80'(fill_count), 80'(37));
        rst = 1'b0;
        #1;
        checkOutput("e_rstFill", 80'(fill_count), 80'(0));
        checkOutput("e_rstValid", 80'(frame_valid), 80'(0));
        checkFrame("e_rst", 80'h0, 80'h0, 80'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 80; k++) applyStimulus(3'b010);
        checkOutput("e_valid", 80'(frame_valid), 80'(1));
        checkFrame("e", 80'h0, {80{1'b1}}, 80'h0, 0);

        // Random frames with input gaps and delayed acks.
        prevBits  = 80'h0;
        prevBases = {80{1'b1}};
        prevBob   = 80'h0;
        prevMatch = 0;
        for (int f = 0; f < 20; f++) begin
            expMatch = 0;
            for (int k = 0; k < 80; k++) begin
                d = 3'($urandom_range(0, 7));
                expBits[k]  = d[2];
                expBases[k] = d[1];
                expBob[k]   = d[0];
                if (d[1] == d[0]) expMatch++;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    s_data = 3'($urandom_range(0, 7));
                    @(posedge clk);
                    #1;
                end
                applyStimulus(d);
            end
            ackDelay = $urandom_range(0, 200);
            for (int g = 0; g < ackDelay; g++) begin
                s_data = 3'($urandom_range(0, 7));
                s_valid = g[0];
                @(posedge clk);
                #1;
            end
            s_valid = 1'b0;
            checkOutput("r_stallReady", 80'(s_ready), 80'(0));
            checkFrame("r_held", prevBits, prevBases, prevBob, prevMatch);
            pulseAck();
            checkOutput("r_valid", 80'(frame_valid), 80'(1));
            checkFrame("r_new", expBits, expBases, expBob, expMatch);
            prevBits  = expBits;
            prevBases = expBases;
            prevBob   = expBob;
            prevMatch = expMatch;
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
